// File: rtl/bmp_stream_encoder.sv
// Streams a 24-bpp BMP file (54-byte header, pixels, per-row zero padding); first byte one cycle after start.
// One byte per cycle when byte_ready stays high; output register holds on byte_ready low, pix_ready only when it can load.
module bmp_stream_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] img_width,
    input  logic [15:0] img_height,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, HDR, PIX, PAD, FIN} state_t;

    state_t      state;
    logic [15:0] w_q;
    logic [15:0] h_q;
    logic [15:0] col;
    logic [15:0] row;
    logic [1:0]  pad_q;
    logic [1:0]  pad_cnt;
    logic [1:0]  slot;
    logic [5:0]  hdr_idx;
    logic [31:0] file_size;
    logic [31:0] img_size;
    logic [15:0] pix_q;

    logic        load;
    logic        last_row;
    logic [31:0] stride_c;
    logic [31:0] img_size_c;
    logic [5:0]  sel;
    logic [31:0] field;
    logic [7:0]  hdr_byte;

    assign load      = !byte_valid || byte_ready;
    assign pix_ready = (state == PIX) && (slot == 2'd0) && load;
    assign last_row  = ((row + 16'd1) == h_q);

    assign stride_c   = {16'd0, img_width} * 32'd3 + {30'd0, img_width[1:0]};
    assign img_size_c = stride_c * {16'd0, img_height};

    // Header fields from byte 2 onward sit on 4-byte boundaries offset by 2,
    // so (idx-2) splits cleanly into a word select and a byte lane.
    always_comb begin
        sel   = hdr_idx - 6'd2;
        field = 32'd0;
        case (sel[5:2])
            4'd0:    field = file_size;
            4'd2:    field = 32'd54;
            4'd3:    field = 32'd40;
            4'd4:    field = {16'd0, w_q};
            4'd5:    field = {16'd0, h_q};
            4'd6:    field = 32'h0018_0001;
            4'd8:    field = img_size;
            4'd9:    field = 32'd2835;
            4'd10:   field = 32'd2835;
            default: field = 32'd0;
        endcase
        hdr_byte = field[8*sel[1:0] +: 8];
        if (hdr_idx < 6'd2) begin
            hdr_byte = hdr_idx[0] ? 8'h4D : 8'h42;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            w_q        <= 16'd0;
            h_q        <= 16'd0;
            col        <= 16'd0;
            row        <= 16'd0;
            pad_q      <= 2'd0;
            pad_cnt    <= 2'd0;
            slot       <= 2'd0;
            hdr_idx    <= 6'd0;
            file_size  <= 32'd0;
            img_size   <= 32'd0;
            pix_q      <= 16'd0;
            byte_data  <= 8'd0;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_q        <= img_width;
                        h_q        <= img_height;
                        pad_q      <= img_width[1:0];
                        img_size   <= img_size_c;
                        file_size  <= img_size_c + 32'd54;
                        col        <= 16'd0;
                        row        <= 16'd0;
                        slot       <= 2'd0;
                        pad_cnt    <= 2'd0;
                        hdr_idx    <= 6'd1;
                        byte_data  <= 8'h42;
                        byte_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= HDR;
                    end
                end
                HDR: begin
                    if (load) begin
                        byte_data  <= hdr_byte;
                        byte_valid <= 1'b1;
                        hdr_idx    <= hdr_idx + 6'd1;
                        if (hdr_idx == 6'd53) begin
                            state <= (w_q == 16'd0 || h_q == 16'd0) ? FIN : PIX;
                        end
                    end
                end
                PIX: begin
                    if (load) begin
                        case (slot)
                            2'd0: begin
                                if (pix_valid) begin
                                    byte_data  <= pix_data[23:16];
                                    byte_valid <= 1'b1;
                                    pix_q      <= pix_data[15:0];
                                    slot       <= 2'd1;
                                end else begin
                                    byte_valid <= 1'b0;
                                end
                            end
                            2'd1: begin
                                byte_data  <= pix_q[15:8];
                                byte_valid <= 1'b1;
                                slot       <= 2'd2;
                            end
                            2'd2: begin
                                byte_data  <= pix_q[7:0];
                                byte_valid <= 1'b1;
                                slot       <= 2'd0;
                                if ((col + 16'd1) == w_q) begin
                                    if (pad_q != 2'd0) begin
                                        pad_cnt <= 2'd0;
                                        state   <= PAD;
                                    end else begin
                                        col   <= 16'd0;
                                        row   <= row + 16'd1;
                                        state <= last_row ? FIN : PIX;
                                    end
                                end else begin
                                    col <= col + 16'd1;
                                end
                            end
                            default: slot <= 2'd0;
                        endcase
                    end
                end
                PAD: begin
                    if (load) begin
                        byte_data  <= 8'h00;
                        byte_valid <= 1'b1;
                        pad_cnt    <= pad_cnt + 2'd1;
                        if ((pad_cnt + 2'd1) == pad_q) begin
                            col   <= 16'd0;
                            row   <= row + 16'd1;
                            state <= last_row ? FIN : PIX;
                        end
                    end
                end
                FIN: begin
                    // The final byte is already in the output register; wait for it to leave.
                    if (byte_ready) begin
                        byte_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmp_stream_encoder.sv
// Directed bench for bmp_stream_encoder: scoreboard of expected file bytes checked at every byte transfer.
module tb_bmp_stream_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] img_width = 16'd0;
    logic [15:0] img_height = 16'd0;
    logic [23:0] pix_data = 24'd0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    bmp_stream_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [23:0] pix_mem[$];
    int          cyc = 0;
    int          last_xfer = -10;
    int          done_cnt = 0;
    bit          pr_seen = 1'b0;
    bit          prev_stall = 1'b0;
    bit          prev_done = 1'b0;
    logic [7:0]  prev_data = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Byte-side monitor: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", {31'd0, byte_valid}, 32'd1);
                chk("stall_hold_data", {24'd0, byte_data}, {24'd0, prev_data});
            end
            if (pix_ready) pr_seen = 1'b1;
            if (byte_valid && byte_ready) begin
                got_q.push_back(byte_data);
                last_xfer = cyc;
                if (exp_q.size() == 0)
                    chk("extra_byte", exp_q.size(), 32'd1);
                else
                    chk($sformatf("byte%0d", got_q.size() - 1), {24'd0, byte_data}, {24'd0, exp_q.pop_front()});
            end
            prev_stall = byte_valid && !byte_ready;
            prev_data  = byte_data;
            if (done) begin
                done_cnt++;
                chk("done_after_last", cyc - last_xfer, 32'd1);
                chk("done_busy_low", {31'd0, busy}, 32'd0);
                chk("done_single", {31'd0, prev_done}, 32'd0);
            end
            prev_done = done;
        end
    end

    task automatic push32(input logic [31:0] v);
        for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
    endtask

    task automatic push16(input logic [15:0] v);
        exp_q.push_back(v[7:0]);
        exp_q.push_back(v[15:8]);
    endtask

    task automatic build_expected(input int w, input int h);
        int pad;
        int isz;
        logic [23:0] p;
        pad = w % 4;
        isz = (3 * w + pad) * h;
        exp_q.delete();
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        push32(54 + isz);
        push32(0);
        push32(54);
        push32(40);
        push32(w);
        push32(h);
        push16(1);
        push16(24);
        push32(0);
        push32(isz);
        push32(2835);
        push32(2835);
        push32(0);
        push32(0);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                p = pix_mem[r * w + c];
                exp_q.push_back(p[23:16]);
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
            end
            for (int k = 0; k < pad; k++) exp_q.push_back(8'h00);
        end
    endtask

    task automatic run_image(input int w, input int h, input bit stalls, input int abort_at,
                             input bit inject, input int max_cyc, input int exp_total);
        int p = 0;
        int n = 0;
        int done0;
        bit injected = 1'b0;
        bit aborted = 1'b0;
        build_expected(w, h);
        got_q.delete();
        pr_seen = 1'b0;
        done0 = done_cnt;
        @(posedge clk); #1;
        start      = 1'b1;
        img_width  = w[15:0];
        img_height = h[15:0];
        pix_valid  = 1'b0;
        byte_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_valid", {31'd0, byte_valid}, 32'd1);
        chk("start_byte", {24'd0, byte_data}, 32'h42);
        while (done_cnt == done0 && n < max_cyc && !aborted) begin
            @(posedge clk); #1;
            n++;
            if (stalls) byte_ready = ($urandom_range(0, 2) != 0);
            if (p < pix_mem.size()) begin
                pix_valid = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
                pix_data  = pix_mem[p];
            end else begin
                pix_valid = 1'b0;
            end
            if (inject && !injected && got_q.size() == 10) begin
                start      = 1'b1;
                img_width  = 16'd7;
                img_height = 16'd9;
                injected   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk); #1;
            if (pix_valid && pix_ready) p++;
            if (abort_at >= 0 && got_q.size() >= abort_at) begin
                rst = 1'b0;
                #1;
                chk("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
                chk("rst_byte_data", {24'd0, byte_data}, 32'd0);
                chk("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                aborted = 1'b1;
            end
        end
        start     = 1'b0;
        pix_valid = 1'b0;
        if (aborted) begin
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
        end else begin
            chk("done_seen", done_cnt - done0, 32'd1);
            chk("byte_count", got_q.size(), exp_total);
            chk("scoreboard_empty", exp_q.size(), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] px_ref[16];
        px_ref = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00,
                   8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_byte_valid", {31'd0, byte_valid}, 32'd0);
        chk("reset_byte_data", {24'd0, byte_data}, 32'd0);
        chk("reset_pix_ready", {31'd0, pix_ready}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b1;

        // 2x2 image, sink always ready
        pix_mem = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        run_image(2, 2, 1'b0, -1, 1'b0, 500, 70);
        chk("w2_magic", {16'd0, got_q[1], got_q[0]}, 32'h4D42);
        chk("w2_file_size", {got_q[5], got_q[4], got_q[3], got_q[2]}, 32'h46);
        chk("w2_img_size", {got_q[37], got_q[36], got_q[35], got_q[34]}, 32'h10);
        for (int i = 0; i < 16; i++)
            chk($sformatf("w2_pix%0d", i), {24'd0, got_q[54 + i]}, {24'd0, px_ref[i]});

        // 4x1, no padding
        pix_mem.delete();
        for (int i = 0; i < 4; i++) pix_mem.push_back(24'($urandom));
        run_image(4, 1, 1'b0, -1, 1'b0, 500, 66);
        chk("w4_width", {got_q[21], got_q[20], got_q[19], got_q[18]}, 32'd4);

        // 3x1 with random byte_ready and pix_valid gaps
        pix_mem.delete();
        for (int i = 0; i < 3; i++) pix_mem.push_back(24'($urandom));
        run_image(3, 1, 1'b1, -1, 1'b0, 2000, 66);
        chk("w3_pad_tail", {8'd0, got_q[65], got_q[64], got_q[63]}, 32'd0);

        // Header-only file
        pix_mem.delete();
        run_image(5, 0, 1'b0, -1, 1'b0, 500, 54);
        chk("h0_file_size", {got_q[5], got_q[4], got_q[3], got_q[2]}, 32'h36);
        chk("h0_img_size", {got_q[37], got_q[36], got_q[35], got_q[34]}, 32'd0);
        chk("h0_no_pix_ready", {31'd0, pr_seen}, 32'd0);

        // Restart attempt during the header must be ignored
        pix_mem = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        run_image(2, 2, 1'b0, -1, 1'b1, 500, 70);

        // Reset mid-image, then a clean run
        run_image(2, 2, 1'b0, 60, 1'b0, 500, 70);
        run_image(2, 2, 1'b0, -1, 1'b0, 500, 70);
        for (int i = 0; i < 16; i++)
            chk($sformatf("rerun_pix%0d", i), {24'd0, got_q[54 + i]}, {24'd0, px_ref[i]});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
